descrypt_outpkt_collector: RTL and testbench

//  Downstream of one descrypt core's comparator: rebuilds the packets the core sends as 4-bit

---
 rtl/descrypt_outpkt_collector_pkg.sv | 59 +++++
 rtl/descrypt_outpkt_collector_fifo.sv | 70 +++++++
 rtl/descrypt_outpkt_collector.sv | 225 ++++++++++++++++++++++
 tb/tb_descrypt_outpkt_collector.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/descrypt_outpkt_collector_pkg.sv
// ---------------------------------------------------------------------------
// descrypt_outpkt_collector_pkg
//   Shared definitions for the descrypt output-packet collector:
//   - nibble field positions of the first (N1) and second (N2) packet nibbles
//   - record metadata width and field offsets (the metadata sits above addr)
//   - the idle nibble constant
//   - collector FSM state type
//   - pack_meta(): assembles the metadata part of a result record
// ---------------------------------------------------------------------------
package descrypt_outpkt_collector_pkg;

   localparam logic [3:0] NIB_IDLE = 4'h0;

   // N1 = {tag[2:0], 1'b1}
   localparam int N1_MARK_BIT   = 0;
   localparam int N1_TAG_LSB    = 1;

   // N2 = {1'b0, key_valid, equal, batch_complete}; bit 3 must be zero
   localparam int HDR_START_BIT = 3;
   localparam int HDR_KV_BIT    = 2;
   localparam int HDR_EQ_BIT    = 1;
   localparam int HDR_BC_BIT    = 0;

   // Record = {meta[9:0], addr}; meta = {tag[2:0], kv, eq, bc, instance[3:0]}
   localparam int OUTREC_META_W   = 10;
   localparam int OUTREC_TAG_LSB  = 7;
   localparam int OUTREC_KV_BIT   = 6;
   localparam int OUTREC_EQ_BIT   = 5;
   localparam int OUTREC_BC_BIT   = 4;
   localparam int OUTREC_INST_LSB = 0;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HDR   = 3'd1,
      ST_INST  = 3'd2,
      ST_A0    = 3'd3,
      ST_A1    = 3'd4,
      ST_A2    = 3'd5,
      ST_TRAIL = 3'd6
   } state_t;

   function automatic logic [OUTREC_META_W-1:0] pack_meta(
      input logic [2:0] tag,
      input logic       kv,
      input logic       eq,
      input logic       bc,
      input logic [3:0] inst
   );
      logic [OUTREC_META_W-1:0] m;
      m = '0;
      m[OUTREC_TAG_LSB +: 3]  = tag;
      m[OUTREC_KV_BIT]        = kv;
      m[OUTREC_EQ_BIT]        = eq;
      m[OUTREC_BC_BIT]        = bc;
      m[OUTREC_INST_LSB +: 4] = inst;
      return m;
   endfunction

endpackage

// File: rtl/descrypt_outpkt_collector_fifo.sv
// ---------------------------------------------------------------------------
// descrypt_outpkt_collector_fifo
//   Small synchronous FIFO for result records, first-word fall-through.
//   Storage has no reset so it maps onto distributed RAM.
//   A write while full is accepted only when a read happens in the same
//   cycle (the read frees the slot first). Reads while empty are ignored.
//
// Ports
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_wr_en        write request, i_wr_data record to store
//   i_rd_en        pop head (ignored when empty)
//   o_rd_data      head record (valid while !o_empty)
//   o_empty/o_full occupancy flags
//   o_free_cnt     number of free entries
// ---------------------------------------------------------------------------
module descrypt_outpkt_collector_fifo #(
   parameter int WIDTH = 22,
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_wr_en,
   input  logic [WIDTH-1:0]         i_wr_data,
   input  logic                     i_rd_en,
   output logic [WIDTH-1:0]         o_rd_data,
   output logic                     o_empty,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_free_cnt
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_rd_ok;
   logic             w_wr_ok;

   assign o_empty    = (r_count == '0);
   assign o_full     = (r_count == (AW+1)'(DEPTH));
   assign o_free_cnt = (AW+1)'(DEPTH) - r_count;
   assign o_rd_data  = r_mem[r_rd_ptr];

   assign w_rd_ok = i_rd_en & ~o_empty;
   assign w_wr_ok = i_wr_en & (~o_full | w_rd_ok);

   always_ff @(posedge i_clk) begin
      if (w_wr_ok) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_ok) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= r_count + (AW+1)'(w_wr_ok) - (AW+1)'(w_rd_ok);
      end
   end

endmodule

// File: rtl/descrypt_outpkt_collector.sv
// ---------------------------------------------------------------------------
// descrypt_outpkt_collector
//   Rebuilds nibble packets from one descrypt core's comparator into
//   parallel result records and queues them for the output arbiter.
//   Runs entirely in the CMP_CLK domain.
//
//   Optional feature macro: DESCRYPT_OUTPKT_STATS_EN
//     defined   -> adds stat_match / stat_batch saturating counters
//     undefined -> counters and ports absent
//
// Ports
//   CMP_CLK      comparator clock
//   RST          asynchronous active-high reset
//   din          nibble bus from core dout (4'h0 = idle)
//   dout_ready   to core: room for one more complete packet
//   rec_out      {tag, key_valid, equal, batch_complete, instance, addr}
//   rec_valid    FIFO non-empty
//   rec_rd_en    pop FIFO head
//   proto_error  sticky malformed-sequence flag
//   ovf_error    sticky record-dropped-on-full flag
//   stat_match   (macro) committed records with equal=1
//   stat_batch   (macro) committed records with batch_complete=1
//   dbg_state    current collector FSM state
//
// Handshake: a packet may start whenever dout_ready was seen high by the
// core; dout_ready is only high between packets (IDLE/TRAIL) with at least
// two free entries, so the core's one-cycle-stale view never overflows.
// rec_valid/rec_rd_en: the head is popped on any cycle both are high.
// ---------------------------------------------------------------------------
module descrypt_outpkt_collector
   import descrypt_outpkt_collector_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 12
) (
   input  logic                            CMP_CLK,
   input  logic                            RST,
   input  logic [3:0]                      din,
   output logic                            dout_ready,
   output logic [OUTREC_META_W+ADDR_W-1:0] rec_out,
   output logic                            rec_valid,
   input  logic                            rec_rd_en,
   output logic                            proto_error,
   output logic                            ovf_error,
`ifdef DESCRYPT_OUTPKT_STATS_EN
   output logic [15:0]                     stat_match,
   output logic [15:0]                     stat_batch,
`endif
   output logic [2:0]                      dbg_state
);

   localparam int REC_W = OUTREC_META_W + ADDR_W;
   localparam int AW    = $clog2(FIFO_DEPTH);

   state_t          r_state;
   logic [2:0]      r_tag;
   logic            r_kv;
   logic            r_eq;
   logic            r_bc;
   logic [3:0]      r_inst;
   logic [11:0]     r_addr;
   logic            r_commit;
   logic            r_proto;
   logic            r_ovf;
   logic            r_dout_ready;

   logic [REC_W-1:0] w_rec;
   logic             w_empty;
   logic             w_full;
   logic [AW:0]      w_free_cnt;
   logic [AW:0]      w_free_nxt;
   logic             w_rd_ok;
   logic             w_wr_ok;
   logic             w_room_nc;
   logic             w_room_c;

   assign w_rec = {pack_meta(r_tag, r_kv, r_eq, r_bc, r_inst), r_addr[ADDR_W-1:0]};

   descrypt_outpkt_collector_fifo #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk      (CMP_CLK),
      .i_rst      (RST),
      .i_wr_en    (r_commit),
      .i_wr_data  (w_rec),
      .i_rd_en    (rec_rd_en),
      .o_rd_data  (rec_out),
      .o_empty    (w_empty),
      .o_full     (w_full),
      .o_free_cnt (w_free_cnt)
   );

   // Free entries after this edge, so the registered dout_ready describes
   // the cycle it is visible in rather than the one before.
   assign w_rd_ok    = rec_rd_en & ~w_empty;
   assign w_wr_ok    = r_commit & (~w_full | w_rd_ok);
   assign w_free_nxt = w_free_cnt - (AW+1)'(w_wr_ok) + (AW+1)'(w_rd_ok);
   // nc: no commit pending next cycle; c: a commit will be pending
   assign w_room_nc  = (w_free_nxt >= (AW+1)'(2));
   assign w_room_c   = (w_free_nxt >= (AW+1)'(3));

   always_ff @(posedge CMP_CLK or posedge RST) begin
      if (RST) begin
         r_state      <= ST_IDLE;
         r_tag        <= '0;
         r_kv         <= 1'b0;
         r_eq         <= 1'b0;
         r_bc         <= 1'b0;
         r_inst       <= '0;
         r_addr       <= '0;
         r_commit     <= 1'b0;
         r_proto      <= 1'b0;
         r_dout_ready <= 1'b0;
      end else begin
         r_commit <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (din == NIB_IDLE) begin
                  r_dout_ready <= w_room_nc;
               end else if (din[N1_MARK_BIT]) begin
                  r_tag        <= din[N1_TAG_LSB +: 3];
                  r_state      <= ST_HDR;
                  r_dout_ready <= 1'b0;
               end else begin
                  r_proto      <= 1'b1;
                  r_dout_ready <= w_room_nc;
               end
            end
            ST_HDR: begin
               if (din[HDR_START_BIT] || (!din[HDR_EQ_BIT] && !din[HDR_BC_BIT])) begin
                  r_proto      <= 1'b1;
                  r_state      <= ST_IDLE;
                  r_dout_ready <= w_room_nc;
               end else begin
                  r_kv <= din[HDR_KV_BIT];
                  r_eq <= din[HDR_EQ_BIT];
                  r_bc <= din[HDR_BC_BIT];
                  if (din[HDR_EQ_BIT]) begin
                     r_state      <= ST_INST;
                     r_dout_ready <= 1'b0;
                  end else begin
                     // batch-complete-only record: no payload nibbles follow
                     r_inst       <= '0;
                     r_addr       <= '0;
                     r_commit     <= 1'b1;
                     r_state      <= ST_TRAIL;
                     r_dout_ready <= w_room_c;
                  end
               end
            end
            ST_INST: begin
               r_inst       <= din;
               r_state      <= ST_A0;
               r_dout_ready <= 1'b0;
            end
            ST_A0: begin
               r_addr[3:0]  <= din;
               r_state      <= ST_A1;
               r_dout_ready <= 1'b0;
            end
            ST_A1: begin
               r_addr[7:4]  <= din;
               r_state      <= ST_A2;
               r_dout_ready <= 1'b0;
            end
            ST_A2: begin
               r_addr[11:8] <= din;
               r_commit     <= 1'b1;
               r_state      <= ST_TRAIL;
               r_dout_ready <= w_room_c;
            end
            ST_TRAIL: begin
               // a nonzero nibble here is an error, never the start of a new packet
               if (din != NIB_IDLE) begin
                  r_proto <= 1'b1;
               end
               r_state      <= ST_IDLE;
               r_dout_ready <= w_room_nc;
            end
            default: begin
               r_state      <= ST_IDLE;
               r_dout_ready <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CMP_CLK or posedge RST) begin
      if (RST) begin
         r_ovf <= 1'b0;
      end else if (r_commit && !w_wr_ok) begin
         r_ovf <= 1'b1;
      end
   end

`ifdef DESCRYPT_OUTPKT_STATS_EN
   logic [15:0] r_stat_match;
   logic [15:0] r_stat_batch;

   always_ff @(posedge CMP_CLK or posedge RST) begin
      if (RST) begin
         r_stat_match <= '0;
         r_stat_batch <= '0;
      end else if (r_commit) begin
         if (r_eq && (r_stat_match != 16'hFFFF)) begin
            r_stat_match <= r_stat_match + 16'd1;
         end
         if (r_bc && (r_stat_batch != 16'hFFFF)) begin
            r_stat_batch <= r_stat_batch + 16'd1;
         end
      end
   end

   assign stat_match = r_stat_match;
   assign stat_batch = r_stat_batch;
`endif

   assign dout_ready  = r_dout_ready;
   assign rec_valid   = ~w_empty;
   assign proto_error = r_proto;
   assign ovf_error   = r_ovf;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_descrypt_outpkt_collector.sv
// ---------------------------------------------------------------------------
// tb_descrypt_outpkt_collector
//   Drives nibble packets into the collector and compares every cycle
//   against a packet-level reference model (queue of expected records).
//   Define DESCRYPT_OUTPKT_STATS_EN to also exercise the statistics ports.
// ---------------------------------------------------------------------------
module tb_descrypt_outpkt_collector;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 12;
   localparam int REC_W  = 10 + ADDR_W;

   // ---------------- clock / reset ----------------
   logic             CMP_CLK = 1'b0;
   logic             RST = 1'b1;
   logic [3:0]       din = 4'h0;
   logic             rec_rd_en = 1'b0;
   logic             dout_ready;
   logic             rec_valid;
   logic             proto_error;
   logic             ovf_error;
   logic [REC_W-1:0] rec_out;
   logic [2:0]       dbg_state;
`ifdef DESCRYPT_OUTPKT_STATS_EN
   logic [15:0]      stat_match;
   logic [15:0]      stat_batch;
`endif

   always #5 CMP_CLK = ~CMP_CLK;

   descrypt_outpkt_collector #(
      .FIFO_DEPTH (DEPTH),
      .ADDR_W     (ADDR_W)
   ) dut (
      .CMP_CLK     (CMP_CLK),
      .RST         (RST),
      .din         (din),
      .dout_ready  (dout_ready),
      .rec_out     (rec_out),
      .rec_valid   (rec_valid),
      .rec_rd_en   (rec_rd_en),
      .proto_error (proto_error),
      .ovf_error   (ovf_error),
`ifdef DESCRYPT_OUTPKT_STATS_EN
      .stat_match  (stat_match),
      .stat_batch  (stat_batch),
`endif
      .dbg_state   (dbg_state)
   );

   // ---------------- check bookkeeping ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // m_pos: 0 = between packets, 1 = expecting header nibble,
   // 2..5 = expecting payload nibble (instance, addr lo/mid/hi), 6 = expecting trailer
   int               m_pos;
   logic [2:0]       m_tag;
   logic             m_kv, m_eq, m_bc;
   logic [3:0]       m_inst;
   logic [11:0]      m_addr;
   logic [REC_W-1:0] exp_q[$];
   bit               m_pend;
   logic [REC_W-1:0] m_pend_rec;
   bit               m_proto, m_ovf, m_live;
   int               m_match, m_batch;

   function automatic logic [REC_W-1:0] mk_rec(input logic [2:0] tag, input logic kv,
         input logic eq, input logic bc, input logic [3:0] inst, input logic [11:0] addr);
      return {tag, kv, eq, bc, inst, addr};
   endfunction

   always @(posedge CMP_CLK) begin
      if (RST) begin
         m_pos = 0; m_pend = 0; m_proto = 0; m_ovf = 0; m_live = 0;
         m_match = 0; m_batch = 0;
         exp_q.delete();
      end else begin
         m_live = 1;
         // a pop frees its slot before the pending record is written
         if (rec_rd_en && exp_q.size() > 0) void'(exp_q.pop_front());
         if (m_pend) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(m_pend_rec);
            else m_ovf = 1;
            if (m_pend_rec[REC_W-5]) m_match++;
            if (m_pend_rec[REC_W-6]) m_batch++;
            m_pend = 0;
         end
         case (m_pos)
            0: if (din != 4'h0) begin
                  if (din[0]) begin m_tag = din[3:1]; m_pos = 1; end
                  else m_proto = 1;
               end
            1: if (din[3] || (din[1:0] == 2'b00)) begin
                  m_proto = 1; m_pos = 0;
               end else begin
                  m_kv = din[2]; m_eq = din[1]; m_bc = din[0];
                  if (m_eq) m_pos = 2;
                  else begin
                     m_pend_rec = mk_rec(m_tag, m_kv, m_eq, m_bc, 4'h0, 12'h000);
                     m_pend = 1; m_pos = 6;
                  end
               end
            2: begin m_inst = din; m_pos = 3; end
            3: begin m_addr[3:0] = din; m_pos = 4; end
            4: begin m_addr[7:4] = din; m_pos = 5; end
            5: begin
                  m_addr[11:8] = din;
                  m_pend_rec = mk_rec(m_tag, m_kv, m_eq, m_bc, m_inst, m_addr);
                  m_pend = 1; m_pos = 6;
               end
            default: begin
                  if (din != 4'h0) m_proto = 1;
                  m_pos = 0;
               end
         endcase
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge CMP_CLK) begin
      if (RST) begin
         check("rst_rec_valid", rec_valid, 0);
         check("rst_dout_ready", dout_ready, 0);
         check("rst_proto", proto_error, 0);
         check("rst_ovf", ovf_error, 0);
         check("rst_state", dbg_state, 0);
      end else if (m_live) begin
         check("rec_valid", rec_valid, exp_q.size() != 0);
         if (exp_q.size() != 0) check("rec_out", rec_out, exp_q[0]);
         check("dout_ready", dout_ready,
               ((m_pos == 0 || m_pos == 6) && (exp_q.size() + int'(m_pend) <= DEPTH - 2)));
         check("proto_error", proto_error, m_proto);
         check("ovf_error", ovf_error, m_ovf);
`ifdef DESCRYPT_OUTPKT_STATS_EN
         check("stat_match", stat_match, m_match);
         check("stat_batch", stat_batch, m_batch);
`endif
      end
   end

   // ---------------- driver tasks ----------------
   int rd_pct = 0;

   task automatic tick();
      @(negedge CMP_CLK);
      #1;
   endtask

   task automatic drive(input logic [3:0] n);
      din = n;
      rec_rd_en = (rd_pct > 0) ? ($urandom_range(0, 99) < rd_pct) : 1'b0;
      tick();
   endtask

   task automatic pop();
      din = 4'h0;
      rec_rd_en = 1'b1;
      tick();
      rec_rd_en = 1'b0;
   endtask

   task automatic do_reset();
      RST = 1'b1; din = 4'h0; rec_rd_en = 1'b0;
      repeat (3) tick();
      RST = 1'b0;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!dout_ready && n < 300) begin drive(4'h0); n++; end
      if (!dout_ready) begin
         n_checks++;
         $display("FAIL wait_ready: dout_ready stayed 0 for %0d cycles, required 1", n);
      end
   endtask

   task automatic send_pkt(input logic [2:0] tag, input logic kv, input logic eq,
         input logic bc, input logic [3:0] inst, input logic [11:0] addr);
      drive({tag, 1'b1});
      drive({1'b0, kv, eq, bc});
      if (eq) begin
         drive(inst); drive(addr[3:0]); drive(addr[7:4]); drive(addr[11:8]);
      end
      drive(4'h0);
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      int popped;
      int r;
      do_reset();

      // 1: non-match packet
      wait_ready();
      drive(4'h5);
      drive(4'h1);
      check("t1_latency_early", rec_valid, 0);
      drive(4'h0);
      check("t1_valid", rec_valid, 1);
      check("t1_rec", rec_out, 22'h110000);
      check("t1_model", exp_q[0], 22'h110000);
      check("t1_proto", proto_error, 0);
      pop();

      // 2: match packet
      wait_ready();
      drive(4'h3); drive(4'h6); drive(4'h9); drive(4'hC); drive(4'h3); drive(4'hA);
      check("t2_latency_early", rec_valid, 0);
      drive(4'h0);
      check("t2_rec", rec_out, 22'h0E9A3C);
      check("t2_model", exp_q[0], 22'h0E9A3C);
      pop();

      // 3: back-to-back fill, then forced overflow
      do_reset();
      rd_pct = 0;
      send_pkt(3'd1, 1'b0, 1'b0, 1'b1, 4'h0, 12'h0);
      send_pkt(3'd2, 1'b1, 1'b0, 1'b1, 4'h0, 12'h0);
      check("t3_ready_after2", dout_ready, 1);
      send_pkt(3'd3, 1'b0, 1'b0, 1'b1, 4'h0, 12'h0);
      check("t3_ready_after3", dout_ready, 0);
      send_pkt(3'd4, 1'b1, 1'b0, 1'b1, 4'h0, 12'h0);
      check("t3_ovf_before", ovf_error, 0);
      send_pkt(3'd5, 1'b0, 1'b0, 1'b1, 4'h0, 12'h0);
      check("t3_ovf", ovf_error, 1);
      check("t3_head", rec_out, 22'h090000);
      popped = 0;
      while (rec_valid && popped < 10) begin pop(); popped++; end
      check("t3_depth", popped, 4);

      // 4: protocol errors
      do_reset();
      drive(4'h2);
      check("t4_idle_err", proto_error, 1);
      do_reset();
      drive(4'h1); drive(4'h8); drive(4'h0); drive(4'h0);
      check("t4_hdr_err", proto_error, 1);
      check("t4_no_rec", rec_valid, 0);

      // 5: reset in the middle of a match packet
      do_reset();
      wait_ready();
      drive(4'h7); drive(4'h2 | 4'h4); drive(4'h4); drive(4'h5);
      RST = 1'b1;
      repeat (2) tick();
      RST = 1'b0;
      wait_ready();
      send_pkt(3'd6, 1'b1, 1'b1, 1'b1, 4'hF, 12'h123);
      check("t5_rec", rec_out, 22'h37F123);
      pop();

`ifdef DESCRYPT_OUTPKT_STATS_EN
      // 6: statistics
      do_reset();
      rd_pct = 100;
      for (int i = 0; i < 3; i++) begin
         wait_ready();
         send_pkt(3'(i), 1'b1, 1'b1, 1'b0, 4'(i), 12'(i * 7));
      end
      for (int i = 0; i < 2; i++) begin
         wait_ready();
         send_pkt(3'(i), 1'b0, 1'b0, 1'b1, 4'h0, 12'h0);
      end
      drive(4'h0); drive(4'h0);
      check("t6_stat_match", stat_match, 3);
      check("t6_stat_batch", stat_batch, 2);
`endif

      // random traffic, mostly legal with a few malformed packets
      do_reset();
      for (int p = 0; p < 150; p++) begin
         if (p % 50 == 0) rd_pct = (p == 0) ? 60 : ((p == 50) ? 10 : 90);
         wait_ready();
         r = $urandom_range(0, 99);
         if (r < 4) begin
            drive({3'($urandom_range(1, 7)), 1'b0});
         end else if (r < 8) begin
            drive({3'($urandom_range(0, 7)), 1'b1});
            drive({1'b1, 3'($urandom_range(0, 7))});
            drive(4'h0);
         end else if (r < 12) begin
            drive({3'($urandom_range(0, 7)), 1'b1});
            drive({1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1});
            drive(4'($urandom_range(1, 15)));
            drive(4'h0);
         end else begin
            logic e;
            e = 1'($urandom_range(0, 1));
            send_pkt(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), e,
                     e ? 1'($urandom_range(0, 1)) : 1'b1,
                     4'($urandom_range(0, 15)), 12'($urandom_range(0, 4095)));
         end
         repeat ($urandom_range(0, 2)) drive(4'h0);
      end
      rd_pct = 100;
      repeat (10) drive(4'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
